// File: rtl/mem_pkg.sv
// Shared memory-bus definitions: size codes, responder states,
// and the mov/moc handshake levels used by responder and control unit.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic MOV_REQ  = 1'b1;
  localparam logic MOC_ACK  = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int row_bits(input int depth);
    return (depth > 4) ? $clog2(depth / 4) : 1;
  endfunction

  function automatic logic bad_align(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic b;
    b = 1'b0;
    unique case (1'b1)
      sz == SZ_HALF: b = lo[0];
      sz == SZ_WORD: b = |lo;
      sz == SZ_RSVD: b = 1'b1;
      default:       b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Four-lane byte store, lane n holds byte address 4*row+n.
// Per-lane write enables, combinational read, no reset.
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int ROW_W       = row_bits(DEPTH_BYTES)
) (
  input  logic             clk,
  input  logic [ROW_W-1:0] row,
  input  logic [3:0]       we,
  input  logic [3:0][7:0]  wdata,
  output logic [3:0][7:0]  rdata
);

  localparam int ROWS = DEPTH_BYTES / 4;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] ram [ROWS];

    always_ff @(posedge clk) begin
      if (we[l]) ram[row] <= wdata[l];
    end

    assign rdata[l] = ram[row];
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder on a mov/moc handshake.
// Big-endian byte/half/word access with alignment and range checks.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        moc,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int ROW_W = row_bits(DEPTH_BYTES);

  state_e      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        moc_nxt, err_nxt;
  logic [31:0] rdata_nxt;
  logic        latch, access;

  logic        lat_rw;
  logic [1:0]  lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic             bad;
  logic [1:0]       lane;
  logic [ROW_W-1:0] row;
  logic [3:0]       be, we;
  logic [3:0][7:0]  wd_lane, rd_lane;
  logic [31:0]      rd_word;

  assign bad  = bad_align(lat_size, lat_addr[1:0])
             || (lat_addr >= 32'(DEPTH_BYTES));
  assign lane = lat_addr[1:0];
  assign row  = ROW_W'(lat_addr >> 2);

  // lane 0 carries the lowest address, i.e. the most significant byte
  always_comb begin
    be      = 4'b0000;
    wd_lane = '0;
    rd_word = '0;
    unique case (1'b1)
      lat_size == SZ_BYTE: begin
        be      = 4'b0001 << lane;
        wd_lane = {4{lat_wdata[7:0]}};
        rd_word = {24'h0, rd_lane[lane]};
      end
      lat_size == SZ_HALF: begin
        be      = 4'b0011 << lane;
        wd_lane = {2{lat_wdata[7:0], lat_wdata[15:8]}};
        rd_word = {16'h0, rd_lane[lane], rd_lane[lane | 2'd1]};
      end
      lat_size == SZ_WORD: begin
        be      = 4'b1111;
        wd_lane = {lat_wdata[7:0], lat_wdata[15:8],
                   lat_wdata[23:16], lat_wdata[31:24]};
        rd_word = {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]};
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

  assign we = (access && lat_rw == RW_WRITE && !bad) ? be : 4'b0000;

  mem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .ROW_W      (ROW_W)
  ) u_array (
    .clk  (clk),
    .row  (row),
    .we   (we),
    .wdata(wd_lane),
    .rdata(rd_lane)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    moc_nxt   = moc;
    err_nxt   = err;
    rdata_nxt = rdata;
    latch     = 1'b0;
    access    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (mov == MOV_REQ) begin
          latch     = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mov != MOV_REQ) begin
          cnt_nxt   = 4'd0;
          state_nxt = S_IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          access    = 1'b1;
          moc_nxt   = MOC_ACK;
          err_nxt   = bad;
          rdata_nxt = (bad || lat_rw != RW_READ) ? 32'h0 : rd_word;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (mov != MOV_REQ) begin
          moc_nxt   = 1'b0;
          err_nxt   = 1'b0;
          rdata_nxt = 32'h0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      moc   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      moc   <= moc_nxt;
      err   <= err_nxt;
      rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_rw    <= 1'b0;
      lat_size  <= 2'b00;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
    end else if (latch) begin
      lat_rw    <= rw;
      lat_size  <= size;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_BYTES, default 512: byte capacity of the backing store; power of two, 4..65536.
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait states inserted before each access completes; 0..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mov  input  1  memory operation valid, driven by the initiator (control unit).
REQ-006 rw  input  1  1 = read, 0 = write.
REQ-007 size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-008 addr  input  32  byte address, from MAR.
REQ-009 wdata  input  32  write data from MDR, right-aligned.
REQ-010 moc  output  1  memory operation complete.
REQ-011 rdata  output  32  read data, right-aligned and zero-extended.
REQ-012 err  output  1  the completed operation was rejected; qualified by moc.

Function
REQ-013 The block SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with mov=1 at an edge, the block SHALL latch rw, size, addr and wdata, load wait counter=WAIT_CYCLES, and enter BUSY.
REQ-015 Request inputs SHALL be ignored after latching until the next entry into IDLE.
REQ-016 In BUSY with counter>0 and mov=1, the counter SHALL decrement by 1 per edge.
REQ-017 In BUSY with counter=0 and mov=1, the access SHALL be performed, moc and err registered, and the FSM SHALL enter DONE.
REQ-018 moc SHALL therefore first be high WAIT_CYCLES+1 edges after the edge that sampled mov.
REQ-019 In DONE, moc, err and rdata SHALL hold until mov is sampled 0; on that edge moc, err and rdata SHALL clear to 0 and the FSM SHALL enter IDLE.
REQ-020 A new request SHALL be accepted no earlier than the edge after the return to IDLE; minimum turnaround is one IDLE cycle.
REQ-021 If mov is sampled 0 in BUSY (abort), the block SHALL return to IDLE with no write committed and moc never asserted.
REQ-022 Storage SHALL be big-endian: word at address A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}; halfword = {mem[A], mem[A+1]}.
REQ-023 A write SHALL update only the bytes selected by size, using wdata[7:0], [15:0] or [31:0].
REQ-024 A read SHALL return the selected bytes in rdata LSBs, with upper bits 0.
REQ-025 A request SHALL be an error when any of the following holds: size=11; halfword with addr[0]=1; word with addr[1:0]!=00; addr>=DEPTH_BYTES.
REQ-026 On an error, the block SHALL complete normally with moc=1, err=1, rdata=0, and no storage modified.

Reset
REQ-027 While reset=0, the FSM SHALL be IDLE, counter=0, moc=0, err=0 and rdata=0, asynchronously.
REQ-028 Reset asserted mid-operation SHALL abandon the operation; a write not yet committed per REQ-017 SHALL NOT occur.
REQ-029 Storage contents SHALL NOT be reset.

Structure
REQ-030 The size encodings, FSM state encodings and the mov/moc handshake definitions SHALL live in a shared package, mem_pkg, also used by the control unit.
REQ-031 The byte array SHALL be a sub-module, mem_byte_array, with 4 byte lanes, a per-lane write enable, and a combinational read.
REQ-032 The FSM, counter, alignment/range checking and lane steering SHALL reside in mem_responder.

Verification
REQ-033 Word round trip: write addr=0x10, wdata=0xDEADBEEF, size=10; then read word 0x10 -> rdata=0xDEADBEEF, err=0; moc rises exactly 3 edges after the sampling edge (WAIT_CYCLES=2).
REQ-034 Endianness: after REQ-033, byte read 0x11 -> 0x000000AD; halfword read 0x12 -> 0x0000BEEF.
REQ-035 Partial write: byte write 0x13 with 0x55; then word read 0x10 -> 0xDEADBE55.
REQ-036 Errors: each of the following -> moc=1, err=1, rdata=0, and a subsequent word read 0x10 unchanged:
- word read 0x12;
- halfword write 0x11;
- size=11;
- addr=0x200 (DEPTH_BYTES=512).
REQ-037 Abort and reset: drop mov one cycle into BUSY of write 0x20=0x12345678 -> moc stays 0 and a read of 0x20 returns its prior value. Separately, assert reset in BUSY -> moc=0 immediately and no write occurs.
REQ-038 Handshake hold: keep mov high 5 cycles in DONE -> moc and rdata stable; drop mov -> moc=0 on the next edge, and a new request is accepted only after one IDLE cycle.
